// File: rtl/fetch_icache_if.sv
// fetch_icache_if: word-serial refill bus between the instruction cache (master)
// and backing memory (slave).
interface fetch_icache_if #(parameter int XLEN = 32, parameter int ILEN = 32);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [ILEN-1:0] mem_data;
    modport master (output mem_req, mem_addr, input mem_ack, mem_data);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/fetch_icache.sv
// fetch_icache: direct-mapped read-only L1 instruction cache with combinational
// lookup and in-order word-by-word line refill.
module fetch_icache #(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  req_addr,
    output logic             rsp_miss,
    output logic [ILEN-1:0]  rsp_data,
    input  logic             flush,
    fetch_icache_if.master   mem
);
    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = XLEN - 2 - WB - IB;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t            state, state_n;
    logic [LINES-1:0]  valid;
    logic [TB-1:0]     tag_mem [LINES];
    logic [ILEN-1:0]   data_mem [LINES][WORDS];
    logic [TB-1:0]     r_tag;
    logic [IB-1:0]     r_index;
    logic [WB-1:0]     cnt;
    logic              discard;
    logic [WB-1:0]     word;
    logic [IB-1:0]     index;
    logic [TB-1:0]     tag;
    logic              hit;
    logic              start;
    logic              last;

    assign word  = req_addr[2 +: WB];
    assign index = req_addr[2 + WB +: IB];
    assign tag   = req_addr[XLEN-1 -: TB];
    assign hit   = state == IDLE && valid[index] && tag_mem[index] == tag;
    assign start = state == IDLE && !hit && !flush;
    assign last  = state == REFILL && mem.mem_ack && cnt == WB'(WORDS - 1);

    always_comb begin
        state_n      = start ? REFILL : last ? IDLE : state;
        rsp_miss     = !hit;
        rsp_data     = hit ? data_mem[index][word] : '0;
        mem.mem_req  = state == REFILL;
        mem.mem_addr = state == REFILL ? {r_tag, r_index, cnt, 2'b00} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            cnt     <= '0;
            discard <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                r_tag        <= tag;
                r_index      <= index;
                cnt          <= '0;
                discard      <= 1'b0;
                valid[index] <= 1'b0;
            end
            if (state == REFILL && mem.mem_ack)
                cnt <= cnt + 1'b1;
            if (last)
                valid[r_index] <= !discard;
            // flush wins over any line install in the same cycle
            if (flush) begin
                valid <= '0;
                if (state == REFILL)
                    discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem.mem_ack)
            data_mem[r_index][cnt] <= mem.mem_data;
        if (last)
            tag_mem[r_index] <= r_tag;
    end
endmodule
